// File: rtl/vga_cell_fetch_pkg.sv
// Shared constants for the VGA cell-colour fetch block: colour packing,
// visible raster size and cell geometry.
package vga_cell_fetch_pkg;

  localparam int unsigned CLR_B_W = 2;
  localparam int unsigned CLR_G_W = 3;
  localparam int unsigned CLR_R_W = 3;
  localparam int unsigned CLR_W   = CLR_B_W + CLR_G_W + CLR_R_W;

  localparam int unsigned VIS_W   = 640;
  localparam int unsigned VIS_H   = 480;
  localparam int unsigned COORD_W = 10;

  localparam int unsigned CELL_SHIFT    = 3;
  localparam int unsigned DEF_CELL_COLS = 80;
  localparam int unsigned DEF_CELL_ROWS = 60;
  localparam int unsigned CELL_AW       = 13;

  typedef enum logic {
    SRC_RAM,
    SRC_BLANK
  } pxl_src_e;

endpackage

// File: rtl/vga_cell_fetch_cell_ram.sv
// Single-port synchronous cell colour RAM with registered read data;
// read data holds when no read is issued. Contents are not reset.
module cell_ram #(
  parameter int unsigned DEPTH = 4800,
  parameter int unsigned AW    = 13,
  parameter int unsigned DW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/vga_cell_fetch.sv
// Maps the current pixel to its 8x8 cell, fetches the cell colour from a
// shared single-port RAM and presents it two clocks after the pixel strobe.
module vga_cell_fetch
  import vga_cell_fetch_pkg::*;
#(
  parameter int unsigned      CELL_COLS = DEF_CELL_COLS,
  parameter int unsigned      CELL_ROWS = DEF_CELL_ROWS,
  parameter logic [CLR_W-1:0] BLANK_CLR = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pxl_en,
  input  logic                 in_frame,
  input  logic [COORD_W-1:0]   x,
  input  logic [COORD_W-1:0]   y,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [CELL_AW-1:0]   wr_addr,
  input  logic [CLR_W-1:0]     wr_data,
  output logic [CLR_W-1:0]     pxl_clr,
  output logic                 pxl_vld
);

  localparam int unsigned NUM_CELLS = CELL_COLS * CELL_ROWS;
  localparam int unsigned CELL_W    = COORD_W - CELL_SHIFT;

  logic [CELL_W-1:0]  cell_row;
  logic [CELL_W-1:0]  cell_col;
  logic [CELL_AW-1:0] rd_addr;
  logic [CELL_AW-1:0] ram_addr;
  logic [CLR_W-1:0]   ram_q;
  logic               visible;
  logic               rd_en;
  logic               wr_en;
  logic               s1_vld;
  pxl_src_e           s1_src;

  assign cell_row = y[COORD_W-1:CELL_SHIFT];
  assign cell_col = x[COORD_W-1:CELL_SHIFT];

  // Constant-coefficient multiply by CELL_COLS as a sum of shifted rows.
  always_comb begin
    rd_addr = CELL_AW'(cell_col);
    for (int unsigned i = 0; i < CELL_AW; i++) begin
      if (CELL_COLS[i]) rd_addr = rd_addr + (CELL_AW'(cell_row) << i);
    end
  end

  assign visible  = in_frame && (x < COORD_W'(VIS_W)) && (y < COORD_W'(VIS_H));
  assign rd_en    = pxl_en && visible;
  assign wr_ready = !(pxl_en && in_frame);
  assign wr_en    = wr_valid && wr_ready && (wr_addr < CELL_AW'(NUM_CELLS));
  assign ram_addr = rd_en ? rd_addr : wr_addr;

  cell_ram #(
    .DEPTH (NUM_CELLS),
    .AW    (CELL_AW),
    .DW    (CLR_W)
  ) u_cell_ram (
    .clk   (clk),
    .we    (wr_en),
    .re    (rd_en),
    .addr  (ram_addr),
    .wdata (wr_data),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_src <= SRC_BLANK;
    end else begin
      s1_vld <= pxl_en;
      s1_src <= rd_en ? SRC_RAM : SRC_BLANK;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pxl_vld <= 1'b0;
      pxl_clr <= '0;
    end else begin
      pxl_vld <= s1_vld;
      if (s1_vld) pxl_clr <= (s1_src == SRC_BLANK) ? BLANK_CLR : ram_q;
    end
  end

endmodule

// File: tb/tb_vga_cell_fetch.sv
// Self-checking bench for vga_cell_fetch: directed stimulus, a cell-array
// reference model checked every cycle, and literal spot checks.
module tb_vga_cell_fetch;

  localparam logic [7:0] BLANK = 8'h3C;
  localparam int         COLS  = 80;
  localparam int         ROWS  = 60;
  localparam int         CELLS = COLS * ROWS;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pxl_en;
  logic        in_frame;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        wr_valid;
  logic        wr_ready;
  logic [12:0] wr_addr;
  logic [7:0]  wr_data;
  logic [7:0]  pxl_clr;
  logic        pxl_vld;

  int tests = 0;
  int fails = 0;

  vga_cell_fetch #(
    .CELL_COLS (COLS),
    .CELL_ROWS (ROWS),
    .BLANK_CLR (BLANK)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pxl_en   (pxl_en),
    .in_frame (in_frame),
    .x        (x),
    .y        (y),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .pxl_clr  (pxl_clr),
    .pxl_vld  (pxl_vld)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: cell array plus a schedule of outputs due two cycles on.
  logic [7:0] mmem [CELLS];
  bit         mknown [CELLS];
  bit         exp_v [4];
  logic [7:0] exp_c [4];
  bit         exp_k [4];
  logic [7:0] held = 8'h00;
  bit         held_k = 1'b1;
  int         cyc = 0;

  always @(negedge clk) begin
    int s, t, a;
    s = cyc % 4;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) exp_v[i] = 1'b0;
      held   = 8'h00;
      held_k = 1'b1;
      chk("rst_vld", {15'd0, pxl_vld}, 16'd0);
      chk("rst_clr", {8'd0, pxl_clr}, 16'd0);
    end else begin
      chk("vld", {15'd0, pxl_vld}, {15'd0, exp_v[s]});
      if (exp_v[s]) begin
        held   = exp_c[s];
        held_k = exp_k[s];
      end
      if (held_k) chk("clr", {8'd0, pxl_clr}, {8'd0, held});
      exp_v[s] = 1'b0;
      chk("wr_ready", {15'd0, wr_ready}, {15'd0, !(pxl_en && in_frame)});
      if (pxl_en) begin
        t = (cyc + 2) % 4;
        exp_v[t] = 1'b1;
        if (in_frame && x < 640 && y < 480) begin
          a = (y / 8) * COLS + (x / 8);
          exp_c[t] = mmem[a];
          exp_k[t] = mknown[a];
        end else begin
          exp_c[t] = BLANK;
          exp_k[t] = 1'b1;
        end
      end
      if (wr_valid && !(pxl_en && in_frame) && wr_addr < CELLS) begin
        mmem[wr_addr]   = wr_data;
        mknown[wr_addr] = 1'b1;
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    wr_valid = 1'b1;
    wr_addr  = 13'(a);
    wr_data  = 8'(d);
    #1;
    for (int k = 0; k < 20 && !wr_ready; k++) step();
    chk("wr_handshake", {15'd0, wr_ready}, 16'd1);
    step();
    wr_valid = 1'b0;
  endtask

  task automatic px(input int xx, input int yy, input bit f);
    pxl_en   = 1'b1;
    in_frame = f;
    x        = 10'(xx);
    y        = 10'(yy);
    step();
    pxl_en   = 1'b0;
    in_frame = 1'b0;
  endtask

  task automatic expect_px(input string nm, input logic [7:0] v);
    step();
    chk({nm, "_vld"}, {15'd0, pxl_vld}, 16'd1);
    chk({nm, "_clr"}, {8'd0, pxl_clr}, {8'd0, v});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; pxl_en = 1'b0; in_frame = 1'b0; x = '0; y = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) step();
    chk("reset_vld", {15'd0, pxl_vld}, 16'd0);
    chk("reset_clr", {8'd0, pxl_clr}, 16'd0);
    rst_n = 1'b1;
    step();

    wr(0, 8'hFF);
    px(0, 0, 1'b1);
    expect_px("cell0", 8'hFF);

    wr(81, 8'h07);
    wr(82, 8'h5A);
    px(15, 8, 1'b1);
    expect_px("cell81", 8'h07);
    px(16, 8, 1'b1);
    expect_px("cell82", 8'h5A);

    px(0, 0, 1'b0);
    expect_px("blank_nf", BLANK);
    px(640, 0, 1'b1);
    expect_px("blank_x640", BLANK);
    px(0, 480, 1'b1);
    expect_px("blank_y480", BLANK);

    // Write held across a visible read: blocked one cycle, then accepted.
    wr(1, 8'h22);
    wr(5, 8'h99);
    wr_valid = 1'b1; wr_addr = 13'd5; wr_data = 8'h11;
    pxl_en = 1'b1; in_frame = 1'b1; x = 10'd8; y = 10'd0;
    #1 chk("wr_blocked", {15'd0, wr_ready}, 16'd0);
    step();
    pxl_en = 1'b0; in_frame = 1'b0;
    #1 chk("wr_open", {15'd0, wr_ready}, 16'd1);
    step();
    wr_valid = 1'b0;
    chk("cell1_vld", {15'd0, pxl_vld}, 16'd1);
    chk("cell1_clr", {8'd0, pxl_clr}, 16'h22);
    px(40, 0, 1'b1);
    expect_px("cell5_new", 8'h11);

    wr(4799, 8'h33);
    wr(4800, 8'hAA);
    px(639, 479, 1'b1);
    expect_px("cell4799", 8'h33);
    px(0, 0, 1'b1);
    expect_px("cell0_kept", 8'hFF);

    wr(100, 8'h44);
    px(160, 8, 1'b1);
    expect_px("wr_then_rd", 8'h44);

    // Back-to-back strobes including a blank slot.
    pxl_en = 1'b1; in_frame = 1'b1; x = 10'd0;  y = 10'd0; step();
    x = 10'd15; y = 10'd8; step();
    in_frame = 1'b0; step();
    in_frame = 1'b1; x = 10'd16; y = 10'd9; step();
    pxl_en = 1'b0; in_frame = 1'b0;
    repeat (4) step();

    // Reset one cycle after a read issues: that read must never emerge.
    wr(0, 8'h77);
    px(0, 0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_vld", {15'd0, pxl_vld}, 16'd0);
    chk("midrst_clr", {8'd0, pxl_clr}, 16'd0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) begin
      step();
      chk("no_stale_vld", {15'd0, pxl_vld}, 16'd0);
    end

    for (int i = 0; i < 80; i++) wr(160 + i, (i * 37 + 5) & 255);
    for (int i = 0; i < 80; i++) begin
      px(i * 8 + (i % 8), 16 + (i % 8), 1'b1);
      repeat (3) step();
    end
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
